// File: rtl/dmem_arbiter_if.sv
//------------------------------------------------------------------------------
// dmem_arbiter_if
//
// Bundles every bus signal of dmem_arbiter: the two requester ports
// (port 0 = processor load/store, port 1 = debug/VIO), the dmem-facing bus
// and the busy flag. Clock and reset stay outside as plain module ports.
//
// Signals:
//   req0/req1       request, held high until the matching ack
//   we0/we1         byte write enables, 0 = read
//   addr0/addr1     access address
//   wdata0/wdata1   write data
//   ack0/ack1       one-cycle completion pulse
//   rdata0/rdata1   read data, valid with ack, held otherwise
//   dmem_we         to dmem we
//   dmem_addr       to dmem daddr
//   dmem_wdata      to dmem indata
//   dmem_rdata      from dmem outdata
//   busy            arbiter has an access in flight
//
// Modports:
//   slave   arbiter side
//   master  environment side (the requesters plus the dmem instance)
//------------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int BW = DW / 8;

  logic          req0;
  logic          req1;
  logic [BW-1:0] we0;
  logic [BW-1:0] we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic [BW-1:0] dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dmem_rdata,
    output ack0, ack1, rdata0, rdata1, dmem_we, dmem_addr, dmem_wdata, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, dmem_rdata,
    input  ack0, ack1, rdata0, rdata1, dmem_we, dmem_addr, dmem_wdata, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one data memory between the processor load/store port (port 0) and
// the debug/VIO port (port 1). Requests are serialised with a round-robin
// pointer; each access takes IDLE -> ISSUE -> CAPT and is acknowledged with a
// one-cycle pulse in the following IDLE cycle, together with the data dmem
// returned for the accessed word.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  synchronous, active-high reset
//   bus    dmem_arbiter_if.slave: requester ports, dmem bus and busy flag
//
// Timing (request sampled in IDLE at cycle N):
//   N+1 ISSUE : dmem_we/addr/wdata presented, write commits at end of cycle
//   N+2 CAPT  : dmem_rdata valid, captured into the winner's rdata
//   N+3 IDLE  : ack pulse; the other port may be granted in this same cycle
//------------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);
  localparam int BW = DW / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2
  } state_e;

  state_e        state_q;
  logic          prio_q;      // port that wins when both request
  logic          winner_q;    // port owning the access in flight
  logic          ack0_q;
  logic          ack1_q;
  logic          busy_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic [BW-1:0] dmem_we_q;
  logic [AW-1:0] dmem_addr_q;
  logic [DW-1:0] dmem_wdata_q;

  // Arbitration decision for the current IDLE cycle.
  logic          req0_m;
  logic          req1_m;
  logic          grant_d;
  logic          winner_d;
  logic [BW-1:0] sel_we_d;
  logic [AW-1:0] sel_addr_d;
  logic [DW-1:0] sel_wdata_d;

  // A port whose ack is high is still holding req from the access that just
  // finished; masking it lets the other port take the next slot instead of
  // the same access being replayed.
  assign req0_m  = bus.req0 & ~ack0_q;
  assign req1_m  = bus.req1 & ~ack1_q;
  assign grant_d = req0_m | req1_m;
  // Lone requester wins; on contention the priority pointer decides.
  assign winner_d = (req0_m & req1_m) ? prio_q : req1_m;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    sel_we_d    = bus.we0;
    sel_addr_d  = bus.addr0;
    sel_wdata_d = bus.wdata0;
    if (winner_d) begin
      sel_we_d    = bus.we1;
      sel_addr_d  = bus.addr1;
      sel_wdata_d = bus.wdata1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the captured-read-data registers are reset too, so a port sees
      // a defined 0 before its first completion; there is no storage array
      // here that would need to be left unreset.
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      winner_q     <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      dmem_we_q    <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // updates from the values seen at the start of the cycle regardless
      // of statement order.
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (grant_d) begin
            // Latched copies are all the access uses from here on, so the
            // requester may change its inputs freely once it sees ack.
            dmem_we_q    <= sel_we_d;
            dmem_addr_q  <= sel_addr_d;
            dmem_wdata_q <= sel_wdata_d;
            winner_q     <= winner_d;
            prio_q       <= ~winner_d;
            busy_q       <= 1'b1;
            state_q      <= ISSUE;
          end
        end

        ISSUE: begin
          // Write enables are presented for exactly one cycle; address and
          // data stay put so dmem_rdata in CAPT refers to this access.
          dmem_we_q <= '0;
          state_q   <= CAPT;
        end

        CAPT: begin
          // Writes capture too: dmem returns the post-write word.
          if (winner_q) begin
            rdata1_q <= bus.dmem_rdata;
            ack1_q   <= 1'b1;
          end else begin
            rdata0_q <= bus.dmem_rdata;
            ack0_q   <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          dmem_we_q <= '0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.rdata0     = rdata0_q;
  assign bus.rdata1     = rdata1_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
//------------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter with a behavioural dmem (synchronous, write-first
// read data, 64 words indexed by daddr[7:2]). Directed vectors cover the
// single-port write/read/byte-enable path, hand sequences cover reset,
// contention, the ack-cycle mask and reset in CAPT, and a random phase runs
// two independent requesters against a transaction-level reference model.
//------------------------------------------------------------------------------
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  //--------------------------------------------------------------------------
  // dmem model
  //--------------------------------------------------------------------------
  logic [31:0] mem [64] = '{default: 32'h0};

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [3:0]  we,
                                        input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.dmem_we != 4'h0)
      mem[bus.dmem_addr[7:2]] <= merge(mem[bus.dmem_addr[7:2]], bus.dmem_we, bus.dmem_wdata);
    bus.dmem_rdata <= merge(mem[bus.dmem_addr[7:2]], bus.dmem_we, bus.dmem_wdata);
  end

  //--------------------------------------------------------------------------
  // helpers
  //--------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_port(input bit p, input logic r, input logic [3:0] we,
                            input logic [31:0] a, input logic [31:0] wd);
    if (!p) begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd;
    end else begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd;
    end
  endtask

  function automatic logic get_ack(input bit p);
    return p ? bus.ack1 : bus.ack0;
  endfunction

  function automatic logic [31:0] get_rdata(input bit p);
    return p ? bus.rdata1 : bus.rdata0;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_ack0"},   bus.ack0,       32'h0);
    check({tag, "_ack1"},   bus.ack1,       32'h0);
    check({tag, "_rdata0"}, bus.rdata0,     32'h0);
    check({tag, "_rdata1"}, bus.rdata1,     32'h0);
    check({tag, "_we"},     bus.dmem_we,    32'h0);
    check({tag, "_addr"},   bus.dmem_addr,  32'h0);
    check({tag, "_wdata"},  bus.dmem_wdata, 32'h0);
    check({tag, "_busy"},   bus.busy,       32'h0);
  endtask

  //--------------------------------------------------------------------------
  // directed vectors: one access each, issued from an idle arbiter
  //--------------------------------------------------------------------------
  typedef struct {
    bit          port;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  //--------------------------------------------------------------------------
  // reference model state for the random phase
  //--------------------------------------------------------------------------
  logic [31:0] ref_mem [64];
  bit          inf_v;
  int          inf_g;
  bit          inf_p;
  logic [3:0]  inf_we;
  logic [31:0] inf_addr;
  logic [31:0] inf_wdata;
  logic [31:0] inf_rdata;
  bit          m_prio;
  logic [31:0] exp_rd [2];
  bit          exp_ack [2];
  bit          rq [2];
  logic [3:0]  rwe [2];
  logic [31:0] raddr [2];
  logic [31:0] rwd [2];
  int          ridle [2];

  task automatic new_txn(input int p);
    rq[p]    = 1'b1;
    rwe[p]   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    raddr[p] = $urandom();
    rwd[p]   = $urandom();
  endtask

  // scratch for the hand sequences
  int          n_ack;
  int          n_busy;
  int          cnt [2];
  logic [31:0] rd1_prev;
  bit          drop_next;
  int          first_port;
  bit          m0;
  bit          m1;
  bit          w;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{port: 1'b0, we: 4'hF,    addr: 32'h10, wdata: 32'hDEADBEEF, exp_rdata: 32'hDEADBEEF};
    vecs[1] = '{port: 1'b0, we: 4'h0,    addr: 32'h10, wdata: 32'h0,        exp_rdata: 32'hDEADBEEF};
    vecs[2] = '{port: 1'b1, we: 4'b0010, addr: 32'h10, wdata: 32'h0000AB00, exp_rdata: 32'hDEADABEF};
    vecs[3] = '{port: 1'b1, we: 4'h0,    addr: 32'h10, wdata: 32'h0,        exp_rdata: 32'hDEADABEF};
    vecs[4] = '{port: 1'b0, we: 4'h0,    addr: 32'h10, wdata: 32'h0,        exp_rdata: 32'hDEADABEF};
    vecs[5] = '{port: 1'b1, we: 4'b0001, addr: 32'h20, wdata: 32'h12345678, exp_rdata: 32'h00000078};
    vecs[6] = '{port: 1'b0, we: 4'b1100, addr: 32'h20, wdata: 32'hAABBCCDD, exp_rdata: 32'hAABB0078};

    drive_port(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_port(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    tick();
    check_reset_state("init");
    reset = 1'b0;
    tick();

    // ---- directed single-port accesses ----
    for (int i = 0; i < 7; i++) begin
      drive_port(vecs[i].port, 1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      tick();  // ISSUE
      check($sformatf("v%0d_issue_we", i),   bus.dmem_we,   {28'h0, vecs[i].we});
      check($sformatf("v%0d_issue_addr", i), bus.dmem_addr, vecs[i].addr);
      if (vecs[i].we != 4'h0)
        check($sformatf("v%0d_issue_wdata", i), bus.dmem_wdata, vecs[i].wdata);
      check($sformatf("v%0d_issue_busy", i), bus.busy, 32'h1);
      tick();  // CAPT
      check($sformatf("v%0d_capt_we", i),   bus.dmem_we, 32'h0);
      check($sformatf("v%0d_capt_busy", i), bus.busy,    32'h1);
      check($sformatf("v%0d_capt_ack", i),  get_ack(vecs[i].port), 32'h0);
      tick();  // ack cycle
      check($sformatf("v%0d_ack", i),       get_ack(vecs[i].port),  32'h1);
      check($sformatf("v%0d_ack_other", i), get_ack(!vecs[i].port), 32'h0);
      check($sformatf("v%0d_rdata", i),     get_rdata(vecs[i].port), vecs[i].exp_rdata);
      check($sformatf("v%0d_ack_busy", i),  bus.busy, 32'h0);
      drive_port(vecs[i].port, 1'b0, 4'h0, 32'h0, 32'h0);
      tick();
      check($sformatf("v%0d_ack_pulse", i),  get_ack(vecs[i].port), 32'h0);
      check($sformatf("v%0d_rdata_hold", i), get_rdata(vecs[i].port), vecs[i].exp_rdata);
    end

    // ---- reset with both requests held, then contention for 6 grants ----
    drive_port(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
    drive_port(1'b1, 1'b1, 4'h0, 32'h20, 32'h0);
    reset = 1'b1;
    tick();
    tick();
    check_reset_state("rst2");
    reset    = 1'b0;
    n_ack    = 0;
    cnt[0]   = 0;
    cnt[1]   = 0;
    rd1_prev = 32'h0;
    for (int k = 0; k < 40 && n_ack < 6; k++) begin
      tick();
      check("cont_both_ack", {31'h0, bus.ack0 & bus.ack1}, 32'h0);
      if (bus.ack0 || bus.ack1) begin
        check($sformatf("cont_order%0d", n_ack), bus.ack1, n_ack % 2);
        if (bus.ack0) begin
          check("cont_rdata0", bus.rdata0, 32'hDEADABEF);
          check("cont_rdata1_untouched", bus.rdata1, rd1_prev);
          cnt[0]++;
          if (cnt[0] == 3) drive_port(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        end
        if (bus.ack1) begin
          check("cont_rdata1", bus.rdata1, 32'hAABB0078);
          rd1_prev = bus.rdata1;
          cnt[1]++;
          if (cnt[1] == 3) drive_port(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        end
        n_ack++;
      end
    end
    check("cont_grants", n_ack, 32'd6);
    drive_port(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_port(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    tick();
    check("cont_idle_busy", bus.busy, 32'h0);

    // ---- mask rule: req0 still high during its ack cycle ----
    drive_port(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
    n_ack     = 0;
    n_busy    = 0;
    drop_next = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (drop_next) begin
        drive_port(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drop_next = 1'b0;
      end
      if (bus.ack0) begin
        n_ack++;
        drop_next = 1'b1;
      end
      if (bus.busy) n_busy++;
    end
    check("mask_acks", n_ack, 32'd1);
    check("mask_busy_cycles", n_busy, 32'd2);
    check("mask_busy_end", bus.busy, 32'h0);

    // ---- reset in CAPT of a read ----
    drive_port(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
    tick();  // ISSUE
    tick();  // CAPT
    check("mid_capt_busy", bus.busy, 32'h1);
    reset = 1'b1;
    drive_port(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    check("mid_ack0",   bus.ack0,    32'h0);
    check("mid_ack1",   bus.ack1,    32'h0);
    check("mid_we",     bus.dmem_we, 32'h0);
    check("mid_busy",   bus.busy,    32'h0);
    check("mid_rdata0", bus.rdata0,  32'h0);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("mid_no_late_ack", bus.ack0, 32'h0);
    end
    // priority must be back at port 0: both request, port 0 acks first
    drive_port(1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
    drive_port(1'b1, 1'b1, 4'h0, 32'h20, 32'h0);
    n_ack      = 0;
    first_port = -1;
    for (int k = 0; k < 20 && n_ack < 2; k++) begin
      tick();
      if (bus.ack0 || bus.ack1) begin
        if (first_port < 0) first_port = bus.ack1 ? 1 : 0;
        if (bus.ack0) drive_port(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        if (bus.ack1) drive_port(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
        n_ack++;
      end
    end
    check("mid_prio_first", first_port, 32'd0);
    check("mid_prio_acks",  n_ack,      32'd2);
    tick();
    tick();

    // ---- random phase against the reference model ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    inf_v     = 1'b0;
    inf_g     = 0;
    m_prio    = 1'b0;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    for (int p = 0; p < 2; p++) begin
      rq[p]    = 1'b0;
      ridle[p] = $urandom_range(0, 3);
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_ack[0] = 1'b0;
      exp_ack[1] = 1'b0;
      if (inf_v && cyc == inf_g + 3) begin
        exp_ack[inf_p] = 1'b1;
        exp_rd[inf_p]  = inf_rdata;
      end
      check("rnd_ack0",   bus.ack0,   {31'h0, exp_ack[0]});
      check("rnd_ack1",   bus.ack1,   {31'h0, exp_ack[1]});
      check("rnd_rdata0", bus.rdata0, exp_rd[0]);
      check("rnd_rdata1", bus.rdata1, exp_rd[1]);
      check("rnd_busy",   bus.busy,   {31'h0, (inf_v && cyc > inf_g && cyc < inf_g + 3)});
      check("rnd_we",     bus.dmem_we, (inf_v && cyc == inf_g + 1) ? {28'h0, inf_we} : 32'h0);
      if (inf_v && cyc == inf_g + 1) begin
        check("rnd_addr", bus.dmem_addr, inf_addr);
        if (inf_we != 4'h0) check("rnd_wdata", bus.dmem_wdata, inf_wdata);
      end

      for (int p = 0; p < 2; p++) begin
        if (exp_ack[p]) begin
          ridle[p] = $urandom_range(0, 3);
          if (ridle[p] == 0) new_txn(p);
          else rq[p] = 1'b0;
        end else if (!rq[p]) begin
          if (ridle[p] > 0) ridle[p]--;
          if (ridle[p] == 0) new_txn(p);
        end
        if (rq[p]) drive_port(1'(p), 1'b1, rwe[p], raddr[p], rwd[p]);
        else       drive_port(1'(p), 1'b0, 4'($urandom_range(0, 15)), $urandom(), $urandom());
      end

      // One access at a time; a port is ineligible in the cycle it is acked.
      if (!inf_v || cyc >= inf_g + 3) begin
        m0 = rq[0] && !exp_ack[0];
        m1 = rq[1] && !exp_ack[1];
        if (m0 || m1) begin
          w         = (m0 && m1) ? m_prio : m1;
          inf_v     = 1'b1;
          inf_g     = cyc;
          inf_p     = w;
          inf_we    = rwe[w];
          inf_addr  = raddr[w];
          inf_wdata = rwd[w];
          inf_rdata = merge(ref_mem[inf_addr[7:2]], inf_we, inf_wdata);
          ref_mem[inf_addr[7:2]] = inf_rdata;
          m_prio    = !w;
        end
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
